// File: rtl/gate_truth_scanner_pkg.sv
// Shared constants, state encoding and truth-table helpers for the gate bank self-test.
// GOLDEN packs gate g's expected outputs at [4g+3:4g], nibble bit v = output for {A,B}=v.
package gate_truth_scanner_pkg;

  localparam int G_AND   = 0;
  localparam int G_OR    = 1;
  localparam int G_BUF_A = 2;
  localparam int G_NAND  = 3;
  localparam int G_NOR   = 4;
  localparam int G_XOR   = 5;
  localparam int G_XNOR  = 6;
  localparam int N_GATES = 7;

  localparam logic [27:0] GOLDEN = 28'h9617CE8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [27:0] capture_vec(input logic [27:0] tbl,
                                              input logic [1:0]  vec,
                                              input logic [6:0]  y);
    logic [27:0] r;
    r = tbl;
    for (int g = 0; g < N_GATES; g++) r[4*g + int'(vec)] = y[g];
    return r;
  endfunction

  function automatic logic [6:0] mismatch_mask(input logic [27:0] tbl);
    logic [6:0] m;
    m = '0;
    for (int g = 0; g < N_GATES; g++) m[g] = |(tbl[4*g +: 4] ^ GOLDEN[4*g +: 4]);
    return m;
  endfunction

endpackage

// File: rtl/gate_truth_scanner_if.sv
// Host and gate-bank signals of the scanner. gate_y is driven by the bank, which sits
// on the master side together with the host.
interface gate_truth_scanner_if;
  logic        start;
  logic        abort;
  logic        gate_a;
  logic        gate_b;
  logic [6:0]  gate_y;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  err_mask;
  logic [27:0] table_q;

  modport master (
    output start, abort, gate_y,
    input  gate_a, gate_b, busy, done, pass, err_mask, table_q
  );

  modport slave (
    input  start, abort, gate_y,
    output gate_a, gate_b, busy, done, pass, err_mask, table_q
  );
endinterface

// File: rtl/gate_truth_scanner_settle_timer.sv
// Settle counter: cleared by load, counts while enabled, expire marks the last settle cycle.
module gate_truth_scanner_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load) cnt <= '0;
    else if (en)     cnt <= cnt + 4'd1;
  end

  assign expire = (cnt == 4'(SETTLE - 1));

endmodule

// File: rtl/gate_truth_scanner.sv
// Self-test sequencer for the 7-output two-input gate bank: walks {A,B}=0..3, captures
// the truth table and compares it against GOLDEN.
//   state    | meaning
//   S_IDLE   | waiting for start; outputs hold the last results
//   S_SETTLE | current vec driven on gate_a/gate_b, waiting SETTLE cycles
//   S_SAMPLE | capture gate_y into the vec column of table_q
//   S_CHECK  | build err_mask and pass from table_q
//   S_DONE   | one-cycle done pulse
module gate_truth_scanner
  import gate_truth_scanner_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input logic                  clk,
  input logic                  rst,
  gate_truth_scanner_if.slave  bus
);

  state_t      state;
  logic [1:0]  vec;
  logic        gate_a;
  logic        gate_b;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  err_mask;
  logic [27:0] table_q;

  logic        load;
  logic        en;
  logic        expire;
  logic [6:0]  mask_next;
  logic        abortable;

  assign load      = ((state == S_IDLE) && bus.start) || ((state == S_SAMPLE) && (vec != 2'd3));
  assign en        = (state == S_SETTLE);
  assign mask_next = mismatch_mask(table_q);
  assign abortable = (state == S_SETTLE) || (state == S_SAMPLE) || (state == S_CHECK);

  gate_truth_scanner_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .en     (en),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      vec      <= '0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= '0;
      table_q  <= '0;
    end else begin
      done <= 1'b0;
      // abort leaves pass/err_mask/table_q untouched, including a pending vec-3 sample
      if (bus.abort && abortable) begin
        state  <= S_IDLE;
        busy   <= 1'b0;
        gate_a <= 1'b0;
        gate_b <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              table_q <= '0;
              vec     <= '0;
              gate_a  <= 1'b0;
              gate_b  <= 1'b0;
              busy    <= 1'b1;
              state   <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (expire) state <= S_SAMPLE;
          end
          S_SAMPLE: begin
            table_q <= capture_vec(table_q, vec, bus.gate_y);
            if (vec == 2'd3) begin
              state <= S_CHECK;
            end else begin
              vec              <= vec + 2'd1;
              {gate_a, gate_b} <= vec + 2'd1;
              state            <= S_SETTLE;
            end
          end
          S_CHECK: begin
            err_mask <= mask_next;
            pass     <= (mask_next == '0);
            done     <= 1'b1;
            state    <= S_DONE;
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.gate_a   = gate_a;
  assign bus.gate_b   = gate_b;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass;
  assign bus.err_mask = err_mask;
  assign bus.table_q  = table_q;

endmodule

// File: tb/tb_gate_truth_scanner.sv
// Bench for gate_truth_scanner: two instances (SETTLE=1 and SETTLE=3) with behavioural
// gate banks; expected results are queued at start and checked when done appears.
module tb_gate_truth_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  gate_truth_scanner_if bus1 ();
  gate_truth_scanner_if bus3 ();

  gate_truth_scanner #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  gate_truth_scanner #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  // behavioural bank: [6]XNOR [5]XOR [4]NOR [3]NAND [2]BUF_A [1]OR [0]AND
  function automatic logic [6:0] bank(input logic [1:0] ab, input bit xor_stuck);
    logic a, b;
    a = ab[1];
    b = ab[0];
    return {~(a ^ b), (a ^ b) & ~xor_stuck, ~(a | b), ~(a & b), a, a | b, a & b};
  endfunction

  bit stuck1 = 1'b0;
  bit lag1   = 1'b0;
  logic [1:0] d1_1 = 2'd0, d2_1 = 2'd0, d1_3 = 2'd0, d2_3 = 2'd0;
  always @(posedge clk) begin
    d1_1 <= {bus1.gate_a, bus1.gate_b};
    d2_1 <= d1_1;
    d1_3 <= {bus3.gate_a, bus3.gate_b};
    d2_3 <= d1_3;
  end
  assign bus1.gate_y = bank(lag1 ? d2_1 : {bus1.gate_a, bus1.gate_b}, stuck1);
  assign bus3.gate_y = bank(d2_3, 1'b0);   // bank with two cycles of output lag

  // src packs the {A,B} value the bank actually saw when vec v was sampled, at [2v+1:2v]
  function automatic logic [27:0] exp_table(input logic [7:0] src, input bit xor_stuck);
    logic [27:0] t;
    logic [6:0]  y;
    t = '0;
    for (int v = 0; v < 4; v++) begin
      y = bank(src[2*v +: 2], xor_stuck);
      for (int g = 0; g < 7; g++) t[4*g + v] = y[g];
    end
    return t;
  endfunction

  function automatic logic [6:0] exp_mask(input logic [27:0] tbl);
    logic [27:0] gold;
    logic [6:0]  m;
    gold = 28'h9617CE8;
    m = '0;
    for (int g = 0; g < 7; g++) m[g] = (tbl[4*g +: 4] != gold[4*g +: 4]);
    return m;
  endfunction

  typedef struct {
    int          due;
    logic [27:0] tbl;
    logic [6:0]  mask;
    logic        pass;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dut, input int due, input logic [27:0] tbl);
    exp_t e;
    e.due  = due;
    e.tbl  = tbl;
    e.mask = exp_mask(tbl);
    e.pass = (e.mask == 7'd0);
    if (dut == 1) q1.push_back(e);
    else          q3.push_back(e);
  endtask

  bit pd1 = 1'b0;
  always @(negedge clk) begin
    if (pd1) begin
      chk("dut1 done width", {31'd0, bus1.done}, 32'd0);
      chk("dut1 busy after done", {31'd0, bus1.busy}, 32'd0);
    end
    pd1 = bus1.done;
    if (bus1.done) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut1 unexpected done: got done=1, required done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1 done cycle", cyc, e.due);
        chk("dut1 table_q", {4'd0, bus1.table_q}, {4'd0, e.tbl});
        chk("dut1 err_mask", {25'd0, bus1.err_mask}, {25'd0, e.mask});
        chk("dut1 pass", {31'd0, bus1.pass}, {31'd0, e.pass});
      end
    end
  end

  bit pd3 = 1'b0;
  always @(negedge clk) begin
    if (pd3) chk("dut3 busy after done", {31'd0, bus3.busy}, 32'd0);
    pd3 = bus3.done;
    if (bus3.done) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut3 unexpected done: got done=1, required done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("dut3 done cycle", cyc, e.due);
        chk("dut3 table_q", {4'd0, bus3.table_q}, {4'd0, e.tbl});
        chk("dut3 err_mask", {25'd0, bus3.err_mask}, {25'd0, e.mask});
        chk("dut3 pass", {31'd0, bus3.pass}, {31'd0, e.pass});
      end
    end
  end

  task automatic start1(input logic [27:0] tbl);
    push(1, cyc + 10, tbl);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic drain(input int dut);
    int n;
    n = 0;
    while (((dut == 1) ? q1.size() : q3.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain dut%0d: got %0d results outstanding, required 0", dut,
               (dut == 1) ? q1.size() : q3.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;
    bus3.start = 1'b0;
    bus3.abort = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset busy",     {31'd0, bus1.busy},     32'd0);
    chk("reset done",     {31'd0, bus1.done},     32'd0);
    chk("reset pass",     {31'd0, bus1.pass},     32'd0);
    chk("reset err_mask", {25'd0, bus1.err_mask}, 32'd0);
    chk("reset table_q",  {4'd0, bus1.table_q},   32'd0);
    chk("reset gate_ab",  {30'd0, bus1.gate_a, bus1.gate_b}, 32'd0);
    chk("reset dut3 busy", {31'd0, bus3.busy},    32'd0);
    @(negedge clk);

    // correct bank
    start1(28'h9617CE8);
    drain(1);

    // abort in vec 2 settle after a passing scan: columns 0 and 1 remain captured
    t0 = cyc;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort cycle in vec2", cyc, t0 + 4);
    @(negedge clk);
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.abort = 1'b0;
    chk("abort busy",     {31'd0, bus1.busy},     32'd0);
    chk("abort done",     {31'd0, bus1.done},     32'd0);
    chk("abort gate_ab",  {30'd0, bus1.gate_a, bus1.gate_b}, 32'd0);
    chk("abort pass",     {31'd0, bus1.pass},     32'd1);
    chk("abort err_mask", {25'd0, bus1.err_mask}, 32'd0);
    chk("abort table_q",  {4'd0, bus1.table_q},   {4'd0, 28'h1213020});
    repeat (15) @(negedge clk);

    // lagging bank with SETTLE=1 samples the previous vector's outputs
    lag1 = 1'b1;
    start1(exp_table({2'd2, 2'd1, 2'd0, 2'd0}, 1'b0));
    drain(1);
    lag1 = 1'b0;

    // lagging bank with SETTLE=3
    push(3, cyc + 18, exp_table({2'd3, 2'd2, 2'd1, 2'd0}, 1'b0));
    bus3.start = 1'b1;
    @(negedge clk);
    bus3.start = 1'b0;
    drain(3);

    // XOR output stuck at 0
    stuck1 = 1'b1;
    start1(28'h9017CE8);
    drain(1);
    stuck1 = 1'b0;

    // start pulses mid-scan must not restart or delay done
    start1(28'h9617CE8);
    repeat (2) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (2) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (2) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    drain(1);

    // reset during SAMPLE of vec 1
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst busy",     {31'd0, bus1.busy},     32'd0);
    chk("rst done",     {31'd0, bus1.done},     32'd0);
    chk("rst pass",     {31'd0, bus1.pass},     32'd0);
    chk("rst err_mask", {25'd0, bus1.err_mask}, 32'd0);
    chk("rst table_q",  {4'd0, bus1.table_q},   32'd0);
    chk("rst gate_ab",  {30'd0, bus1.gate_a, bus1.gate_b}, 32'd0);
    repeat (12) @(negedge clk);
    start1(28'h9617CE8);
    drain(1);

    // start held 25 cycles: IDLE is seen at t0, t0+11 and t0+22
    t0 = cyc;
    push(1, t0 + 10, 28'h9617CE8);
    push(1, t0 + 21, 28'h9617CE8);
    push(1, t0 + 32, 28'h9617CE8);
    bus1.start = 1'b1;
    repeat (25) @(negedge clk);
    bus1.start = 1'b0;
    drain(1);
    drain(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
